load_align_unit: RTL and testbench

Parametrised load path between the core's memory stage and the data-memory port, superseding the combinational read-data extender. It accepts one load at a time, aligns the data by byte offset, and sign- or zero-extends it by access size. When enabled, it splits a misaligned access that crosses a bus word into two bus reads and merges the results. If misaligned support is disabled, it instead returns a fault without touching the bus.

---
 rtl/load_align_unit_if.sv | 30 +++
 rtl/load_align_unit.sv | 162 ++++++++++++++++
 tb/tb_load_align_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// Load request/response and data-memory read port bundle for load_align_unit.
// The slave modport is the unit's view; the master modport drives it.
interface load_align_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              i_reqValid;
  logic              o_reqReady;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_memSize;
  logic              i_signed;
  logic              o_respValid;
  logic [XLEN-1:0]   o_respData;
  logic              o_respErr;
  logic              o_memReq;
  logic [ADDR_W-1:0] o_memAddr;
  logic              i_memGnt;
  logic              i_memRValid;
  logic [XLEN-1:0]   i_memData;

  modport slave (
    input  i_reqValid, i_addr, i_memSize, i_signed, i_memGnt, i_memRValid, i_memData,
    output o_reqReady, o_respValid, o_respData, o_respErr, o_memReq, o_memAddr
  );

  modport master (
    output i_reqValid, i_addr, i_memSize, i_signed, i_memGnt, i_memRValid, i_memData,
    input  o_reqReady, o_respValid, o_respData, o_respErr, o_memReq, o_memAddr
  );
endinterface

// File: rtl/load_align_unit.sv
// Load path: aligns and extends load data, splitting word-crossing accesses
// into two bus reads (or faulting them when misaligned support is off).
module load_align_unit #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned ADDR_W           = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst_n,
  load_align_unit_if.slave bus
);
  localparam int unsigned BB  = XLEN / 8;
  localparam int unsigned OW  = $clog2(BB);
  localparam int unsigned NBW = 4;
  localparam int unsigned SW  = NBW + 1;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t            state, stateD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [NBW-1:0]    nbQ, nbD;
  logic [OW-1:0]     offQ, offD;
  logic              signedQ, signedD;
  logic              splitQ, splitD;
  logic [XLEN-1:0]   loQ, loD, hiQ, hiD;

  logic              reqReadyQ, reqReadyD;
  logic              memReqQ, memReqD;
  logic [ADDR_W-1:0] memAddrQ, memAddrD;
  logic              respValidQ, respValidD;
  logic [XLEN-1:0]   respDataQ, respDataD;
  logic              respErrQ, respErrD;

  logic [NBW-1:0]    reqNb;
  logic [OW-1:0]     reqOff;
  logic              reqMis, reqSplit;
  logic [ADDR_W-1:0] srcAddr, alignedAddr;
  logic [XLEN-1:0]   loN, hiN, mLow, fieldMask, extData;
  logic              signBit;

  // Byte count of the incoming request
  always_comb begin
    case (bus.i_memSize)
      2'b00:   reqNb = NBW'(4);
      2'b01:   reqNb = NBW'(2);
      2'b10:   reqNb = NBW'(1);
      default: reqNb = (XLEN == 64) ? NBW'(8) : NBW'(1);
    endcase
  end

  assign reqOff      = bus.i_addr[OW-1:0];
  assign reqMis      = (bus.i_addr[NBW-1:0] & (reqNb - NBW'(1))) != '0;
  assign reqSplit    = (SW'(reqOff) + SW'(reqNb)) > SW'(BB);
  assign srcAddr     = (state == IDLE) ? bus.i_addr : addrQ;
  assign alignedAddr = srcAddr & ~ADDR_W'(BB - 1);

  // Data formation sees the beat arriving this cycle so RESP can register it
  assign loN       = (state == WAIT0 && bus.i_memRValid) ? bus.i_memData : loQ;
  assign hiN       = (state == WAIT1 && bus.i_memRValid) ? bus.i_memData : hiQ;
  assign mLow      = XLEN'({(splitQ ? hiN : {XLEN{1'b0}}), loN} >> {offQ, 3'b000});
  assign fieldMask = ~({XLEN{1'b1}} << {nbQ, 3'b000});
  assign signBit   = |(mLow & fieldMask & ~(fieldMask >> 1));
  assign extData   = (signedQ && signBit) ? (mLow | ~fieldMask) : (mLow & fieldMask);

  always_comb begin
    stateD   = state;
    addrD    = addrQ;
    nbD      = nbQ;
    offD     = offQ;
    signedD  = signedQ;
    splitD   = splitQ;
    loD      = loQ;
    hiD      = hiQ;
    respErrD = 1'b0;

    case (state)
      IDLE: begin
        if (bus.i_reqValid && reqReadyQ) begin
          addrD   = bus.i_addr;
          nbD     = reqNb;
          offD    = reqOff;
          signedD = bus.i_signed;
          splitD  = reqSplit;
          loD     = '0;
          hiD     = '0;
          if (reqMis && !ALLOW_MISALIGNED) begin
            stateD   = RESP;
            respErrD = 1'b1;
          end else begin
            stateD = REQ0;
          end
        end
      end
      REQ0:  if (bus.i_memGnt) stateD = WAIT0;
      WAIT0: begin
        if (bus.i_memRValid) begin
          loD    = bus.i_memData;
          stateD = splitQ ? REQ1 : RESP;
        end
      end
      REQ1:  if (bus.i_memGnt) stateD = WAIT1;
      WAIT1: begin
        if (bus.i_memRValid) begin
          hiD    = bus.i_memData;
          stateD = RESP;
        end
      end
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase

    // Outputs are registered from the next state
    reqReadyD  = (stateD == IDLE);
    memReqD    = (stateD == REQ0) || (stateD == REQ1);
    memAddrD   = '0;
    if (stateD == REQ0) memAddrD = alignedAddr;
    if (stateD == REQ1) memAddrD = alignedAddr + ADDR_W'(BB);
    respValidD = (stateD == RESP);
    respDataD  = (stateD == RESP && !respErrD) ? extData : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      addrQ      <= '0;
      nbQ        <= '0;
      offQ       <= '0;
      signedQ    <= 1'b0;
      splitQ     <= 1'b0;
      loQ        <= '0;
      hiQ        <= '0;
      reqReadyQ  <= 1'b1;
      memReqQ    <= 1'b0;
      memAddrQ   <= '0;
      respValidQ <= 1'b0;
      respDataQ  <= '0;
      respErrQ   <= 1'b0;
    end else begin
      state      <= stateD;
      addrQ      <= addrD;
      nbQ        <= nbD;
      offQ       <= offD;
      signedQ    <= signedD;
      splitQ     <= splitD;
      loQ        <= loD;
      hiQ        <= hiD;
      reqReadyQ  <= reqReadyD;
      memReqQ    <= memReqD;
      memAddrQ   <= memAddrD;
      respValidQ <= respValidD;
      respDataQ  <= respDataD;
      respErrQ   <= respErrD;
    end
  end

  assign bus.o_reqReady  = reqReadyQ;
  assign bus.o_memReq    = memReqQ;
  assign bus.o_memAddr   = memAddrQ;
  assign bus.o_respValid = respValidQ;
  assign bus.o_respData  = respDataQ;
  assign bus.o_respErr   = respErrQ;
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three instances (32-bit, 32-bit faulting, 64-bit)
// against a byte-level memory model and a reference load model.
module tb_load_align_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) ifA ();
  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) ifB ();
  load_align_unit_if #(.XLEN(64), .ADDR_W(32)) ifC ();

  load_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dutA (.i_clk(clk), .i_rst_n(rst_n), .bus(ifA));
  load_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dutB (.i_clk(clk), .i_rst_n(rst_n), .bus(ifB));
  load_align_unit #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dutC (.i_clk(clk), .i_rst_n(rst_n), .bus(ifC));

  int     checks = 0;
  int     errors = 0;
  int     gntDelay = 0;
  int     rvDelay = 0;
  longint cycleCnt = 0;
  longint lastAccept = 0;
  int     lastLat = 0;
  logic [7:0] memB [logic [31:0]];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [7:0] readByte(input logic [31:0] a);
    if (memB.exists(a)) return memB[a];
    return 8'((a * 32'd157) ^ (a >> 11)) ^ 8'h5A;
  endfunction

  function automatic void writeBytes(input logic [31:0] a, input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) memB[a + 32'(i)] = v[8*i +: 8];
  endfunction

  function automatic logic [63:0] busWord(input logic [31:0] a, input int n);
    logic [63:0] w = '0;
    for (int i = 0; i < n; i++) w |= 64'(readByte(a + 32'(i))) << (8 * i);
    return w;
  endfunction

  // Reference: gather nb bytes little-endian from memory, then extend arithmetically
  function automatic void model(input int sel, input logic [31:0] addr, input logic [1:0] size,
                                input logic sgn, output logic [63:0] d, output bit e, output bit sp);
    int xlen = (sel == 2) ? 64 : 32;
    int bb   = xlen / 8;
    int nb;
    int off;
    nb  = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : (size == 2'b10) ? 1 : ((xlen == 64) ? 8 : 1);
    off = int'(addr % 32'(bb));
    sp  = (off + nb) > bb;
    e   = ((addr % 32'(nb)) != 0) && (sel == 1);
    d   = '0;
    if (!e) begin
      for (int i = 0; i < nb; i++) d |= 64'(readByte(addr + 32'(i))) << (8 * i);
      if (sgn && (nb * 8 < xlen) && (((d >> (8 * nb - 1)) & 64'd1) != 0))
        d |= {64{1'b1}} << (8 * nb);
      if (xlen == 32) d &= 64'hFFFF_FFFF;
    end
  endfunction

  function automatic void getOut(input int sel, output logic rv, output logic [63:0] rd, output logic re,
                                 output logic mq, output logic [31:0] ma, output logic rdy);
    case (sel)
      0: begin rv = ifA.o_respValid; rd = 64'(ifA.o_respData); re = ifA.o_respErr;
               mq = ifA.o_memReq; ma = ifA.o_memAddr; rdy = ifA.o_reqReady; end
      1: begin rv = ifB.o_respValid; rd = 64'(ifB.o_respData); re = ifB.o_respErr;
               mq = ifB.o_memReq; ma = ifB.o_memAddr; rdy = ifB.o_reqReady; end
      default: begin rv = ifC.o_respValid; rd = ifC.o_respData; re = ifC.o_respErr;
               mq = ifC.o_memReq; ma = ifC.o_memAddr; rdy = ifC.o_reqReady; end
    endcase
  endfunction

  function automatic void setReq(input int sel, input logic v, input logic [31:0] a,
                                 input logic [1:0] sz, input logic sg);
    case (sel)
      0: begin ifA.i_reqValid = v; ifA.i_addr = a; ifA.i_memSize = sz; ifA.i_signed = sg; end
      1: begin ifB.i_reqValid = v; ifB.i_addr = a; ifB.i_memSize = sz; ifB.i_signed = sg; end
      default: begin ifC.i_reqValid = v; ifC.i_addr = a; ifC.i_memSize = sz; ifC.i_signed = sg; end
    endcase
  endfunction

  function automatic void setBus(input int sel, input logic g, input logic r, input logic [63:0] d);
    case (sel)
      0: begin ifA.i_memGnt = g; ifA.i_memRValid = r; ifA.i_memData = d[31:0]; end
      1: begin ifB.i_memGnt = g; ifB.i_memRValid = r; ifB.i_memData = d[31:0]; end
      default: begin ifC.i_memGnt = g; ifC.i_memRValid = r; ifC.i_memData = d; end
    endcase
  endfunction

  // Memory responder: grant after gntDelay cycles, return data rvDelay cycles after the grant
  int          gCnt [3];
  bit          gPrev [3];
  bit          pend [3];
  int          pCnt [3];
  logic [31:0] gAddr [3];

  always @(negedge clk) begin : responder
    logic rv, re, mq, rdy, g, r;
    logic [63:0] rd, d;
    logic [31:0] ma;
    for (int s = 0; s < 3; s++) begin
      getOut(s, rv, rd, re, mq, ma, rdy);
      g = 1'b0;
      r = 1'b0;
      d = {$urandom, $urandom};
      if (gPrev[s]) begin
        gPrev[s] = 1'b0;
        pend[s]  = 1'b1;
        pCnt[s]  = rvDelay;
      end else if (mq === 1'b1) begin
        if (gCnt[s] >= gntDelay) begin
          g        = 1'b1;
          gPrev[s] = 1'b1;
          gAddr[s] = ma;
          gCnt[s]  = 0;
        end else begin
          gCnt[s]++;
        end
      end else begin
        gCnt[s] = 0;
      end
      if (pend[s]) begin
        if (pCnt[s] == 0) begin
          r       = 1'b1;
          d       = busWord(gAddr[s], (s == 2) ? 8 : 4);
          pend[s] = 1'b0;
        end else begin
          pCnt[s]--;
        end
      end
      setBus(s, g, r, d);
    end
  end

  // One load on instance sel, checked against the model; call and return on a negedge
  task automatic doLoad(input int sel, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, output logic [63:0] got, output logic gotErr);
    logic [63:0] expD, rd;
    bit          expE, expSplit, done, stable, quiet, busy;
    int          bb, expLat, lat;
    logic [31:0] expA [$];
    logic [31:0] seenA [$];
    logic        rv, re, mq, rdy, prevReq;
    logic [31:0] ma, prevAddr;
    string       tag;
    tag = $sformatf("sel%0d_addr%08h_sz%0d_s%0d", sel, addr, size, sgn);
    model(sel, addr, size, sgn, expD, expE, expSplit);
    bb = (sel == 2) ? 8 : 4;
    if (!expE) begin
      expA.push_back(addr & ~32'(bb - 1));
      if (expSplit) expA.push_back((addr & ~32'(bb - 1)) + 32'(bb));
    end
    expLat = expE ? 1 : ((expSplit ? 5 : 3) + expA.size() * (gntDelay + rvDelay));

    getOut(sel, rv, rd, re, mq, ma, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL %s ready_before got %b want 1", tag, rdy); end

    setReq(sel, 1'b1, addr, size, sgn);
    done = 0; stable = 1; quiet = 1; busy = 1; lat = 0; prevReq = 1'b0; prevAddr = '0;
    got = 'x; gotErr = 1'bx;
    for (int c = 1; c <= 80 && !done; c++) begin
      @(negedge clk);
      getOut(sel, rv, rd, re, mq, ma, rdy);
      if (c == 1) lastAccept = cycleCnt;
      if (mq === 1'b1 && prevReq !== 1'b1) seenA.push_back(ma);
      if (mq === 1'b1 && prevReq === 1'b1 && ma !== prevAddr) stable = 0;
      prevReq = mq; prevAddr = ma;
      if (rdy !== 1'b0) busy = 0;
      if (rv === 1'b1) begin
        lat = c; got = rd; gotErr = re; done = 1;
        setReq(sel, 1'b0, '0, 2'b00, 1'b0);
      end else begin
        if (rd !== 64'd0 || re !== 1'b0) quiet = 0;
        setReq(sel, 1'b1, $urandom, 2'($urandom), 1'($urandom));
      end
    end
    lastLat = lat;
    if (!done) begin
      setReq(sel, 1'b0, '0, 2'b00, 1'b0);
      checks++; errors++;
      $display("FAIL %s timeout got no response want latency %0d", tag, expLat);
    end

    checks++;
    if (lat != expLat) begin errors++; $display("FAIL %s latency got %0d want %0d", tag, lat, expLat); end
    checks++;
    if (got !== expD) begin errors++; $display("FAIL %s data got %h want %h", tag, got, expD); end
    checks++;
    if (gotErr !== expE) begin errors++; $display("FAIL %s err got %b want %b", tag, gotErr, expE); end
    checks++;
    if (seenA.size() != expA.size()) begin
      errors++; $display("FAIL %s bus_requests got %0d want %0d", tag, seenA.size(), expA.size());
    end
    for (int i = 0; i < expA.size() && i < seenA.size(); i++) begin
      checks++;
      if (seenA[i] !== expA[i]) begin
        errors++; $display("FAIL %s mem_addr%0d got %h want %h", tag, i, seenA[i], expA[i]);
      end
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL %s addr_stability got unstable want stable", tag); end
    checks++;
    if (!quiet) begin errors++; $display("FAIL %s idle_outputs got nonzero want zero", tag); end
    checks++;
    if (!busy) begin errors++; $display("FAIL %s busy_ready got 1 want 0", tag); end

    @(negedge clk);
    getOut(sel, rv, rd, re, mq, ma, rdy);
    checks++;
    if (rv !== 1'b0 || rdy !== 1'b1 || rd !== 64'd0) begin
      errors++; $display("FAIL %s after_resp got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", tag, rv, rdy, rd);
    end
  endtask

  task automatic test_reset();
    logic rv, re, mq, rdy;
    logic [63:0] rd;
    logic [31:0] ma;
    for (int s = 0; s < 3; s++) begin
      getOut(s, rv, rd, re, mq, ma, rdy);
      checks++;
      if (rdy !== 1'b1 || rv !== 1'b0 || re !== 1'b0 || mq !== 1'b0 || rd !== 64'd0 || ma !== 32'd0) begin
        errors++;
        $display("FAIL reset_sel%0d got rdy=%b v=%b e=%b req=%b d=%h a=%h want 1 0 0 0 0 0", s, rdy, rv, re, mq, rd, ma);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed32();
    logic [63:0] got;
    logic        ge;
    writeBytes(32'h1000, 64'h8012_3456, 4);
    doLoad(0, 32'h1003, 2'b10, 1'b1, got, ge);
    checks++;
    if (got !== 64'hFFFF_FF80 || ge !== 1'b0) begin errors++; $display("FAIL sbyte got %h/%b want ffffff80/0", got, ge); end
    writeBytes(32'h1000, 64'h8001_5555, 4);
    doLoad(0, 32'h1002, 2'b01, 1'b0, got, ge);
    checks++;
    if (got !== 64'h0000_8001) begin errors++; $display("FAIL uhalf got %h want 00008001", got); end
    doLoad(0, 32'h1002, 2'b01, 1'b1, got, ge);
    checks++;
    if (got !== 64'hFFFF_8001) begin errors++; $display("FAIL shalf got %h want ffff8001", got); end
    doLoad(0, 32'h1000, 2'b00, 1'b0, got, ge);
    checks++;
    if (got !== 64'h8001_5555) begin errors++; $display("FAIL uword got %h want 80015555", got); end
    doLoad(0, 32'h1000, 2'b00, 1'b1, got, ge);
    checks++;
    if (got !== 64'h8001_5555) begin errors++; $display("FAIL sword got %h want 80015555", got); end
  endtask

  task automatic test_split();
    logic [63:0] got;
    logic        ge;
    writeBytes(32'h1000, 64'hDDCC_BBAA, 4);
    writeBytes(32'h1004, 64'h4433_2211, 4);
    doLoad(0, 32'h1002, 2'b00, 1'b0, got, ge);
    checks++;
    if (got !== 64'h2211_DDCC || lastLat != 5) begin
      errors++; $display("FAIL split_word got %h lat %0d want 2211ddcc lat 5", got, lastLat);
    end
    doLoad(0, 32'hFFFF_FFFF, 2'b01, 1'b1, got, ge);
  endtask

  task automatic test_fault();
    logic [63:0] got;
    logic        ge;
    doLoad(1, 32'h1001, 2'b01, 1'b0, got, ge);
    checks++;
    if (ge !== 1'b1 || got !== 64'd0 || lastLat != 1) begin
      errors++; $display("FAIL fault_half got err %b data %h lat %0d want 1 0 1", ge, got, lastLat);
    end
    doLoad(1, 32'h1001, 2'b10, 1'b0, got, ge);
    checks++;
    if (ge !== 1'b0 || got !== 64'h0000_00BB) begin
      errors++; $display("FAIL fault_byte got err %b data %h want 0 bb", ge, got);
    end
  endtask

  task automatic test_gnt_stall();
    logic [63:0] got;
    logic        ge;
    gntDelay = 4;
    doLoad(0, 32'h1004, 2'b00, 1'b0, got, ge);
    checks++;
    if (lastLat != 7 || got !== 64'h4433_2211) begin
      errors++; $display("FAIL gnt_stall got lat %0d data %h want 7 44332211", lastLat, got);
    end
    gntDelay = 0;
  endtask

  task automatic test_reset_midop();
    logic rv, re, mq, rdy;
    logic [63:0] rd, got;
    logic [31:0] ma;
    logic        ge;
    bit          stray = 0;
    rvDelay = 3;
    setReq(0, 1'b1, 32'h1000, 2'b00, 1'b0);
    @(negedge clk);
    setReq(0, 1'b0, '0, 2'b00, 1'b0);
    @(negedge clk);
    getOut(0, rv, rd, re, mq, ma, rdy);
    checks++;
    if (mq !== 1'b0 || rdy !== 1'b0) begin errors++; $display("FAIL midop_wait0 got req=%b rdy=%b want 0 0", mq, rdy); end
    rst_n = 1'b0;
    #1;
    getOut(0, rv, rd, re, mq, ma, rdy);
    checks++;
    if (rdy !== 1'b1 || rv !== 1'b0 || re !== 1'b0 || mq !== 1'b0 || rd !== 64'd0 || ma !== 32'd0) begin
      errors++; $display("FAIL midop_reset got rdy=%b v=%b e=%b req=%b d=%h a=%h want 1 0 0 0 0 0", rdy, rv, re, mq, rd, ma);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rvDelay = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      getOut(0, rv, rd, re, mq, ma, rdy);
      if (rv !== 1'b0 || mq !== 1'b0 || rdy !== 1'b1) stray = 1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL stale_rvalid got activity want idle"); end
    doLoad(0, 32'h1000, 2'b00, 1'b0, got, ge);
    checks++;
    if (got !== 64'hDDCC_BBAA) begin errors++; $display("FAIL after_reset_load got %h want ddccbbaa", got); end
  endtask

  task automatic test_xlen64();
    logic [63:0] got;
    logic        ge;
    writeBytes(32'h2000, 64'h8000_0000_1234_5678, 8);
    doLoad(2, 32'h2004, 2'b00, 1'b1, got, ge);
    checks++;
    if (got !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL x64_sword got %h want ffffffff80000000", got); end
    doLoad(2, 32'h2000, 2'b11, 1'b1, got, ge);
    checks++;
    if (got !== 64'h8000_0000_1234_5678) begin errors++; $display("FAIL x64_dword got %h want 8000000012345678", got); end
    doLoad(2, 32'h2005, 2'b11, 1'b0, got, ge);
  endtask

  task automatic test_back_to_back();
    logic [63:0] got;
    logic        ge;
    longint      first;
    doLoad(0, 32'h1000, 2'b10, 1'b0, got, ge);
    first = lastAccept;
    doLoad(0, 32'h1001, 2'b10, 1'b0, got, ge);
    checks++;
    if (lastAccept - first != 4) begin
      errors++; $display("FAIL back_to_back interval got %0d want 4", lastAccept - first);
    end
  endtask

  task automatic test_random();
    logic [63:0] got;
    logic        ge;
    logic [31:0] a;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) writeBytes(32'h3000 + 32'($urandom_range(0, 63)), {$urandom, $urandom}, 8);
      a = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                      : (32'h3000 + 32'($urandom_range(0, 63)));
      gntDelay = $urandom_range(0, 2);
      rvDelay  = $urandom_range(0, 1);
      doLoad($urandom_range(0, 2), a, 2'($urandom), 1'($urandom), got, ge);
    end
    gntDelay = 0;
    rvDelay  = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) setReq(s, 1'b0, '0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    test_directed32();
    test_split();
    test_fault();
    test_gnt_stall();
    test_reset_midop();
    test_xlen64();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "simulation stalled");
  end
endmodule
